// File: rtl/farm_road_sensor.sv
// Roadside vehicle-request generator: conditions the detector loop, queues farm-road
// vehicles, drives the `x` request to the signal controller and watches its lights.
module farm_road_sensor #(
   parameter int DEB_CYC   = 4,
   parameter int DEP_CYC   = 8,
   parameter int MAX_GREEN = 32,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             car_raw,
   input  logic [1:0]       hw,
   input  logic [1:0]       cw,
   output logic             x,
   output logic [CNT_W-1:0] car_count,
   output logic             q_full,
   output logic             light_err
);

   localparam int DEB_W = $clog2(DEB_CYC + 1);
   localparam int DEP_W = $clog2(DEP_CYC + 1);
   localparam int GT_W  = $clog2(MAX_GREEN + 1);

   localparam logic [1:0] RED = 2'b00;
   localparam logic [1:0] GRN = 2'b10;
   localparam logic [1:0] BAD = 2'b11;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, REQUEST, SERVE, YIELD} state_t;

   state_t state, state_nxt;

   logic             sync1, sync2;
   logic             deb_lvl;
   logic [DEB_W-1:0] deb_cnt;
   logic             deb_hit, arrival;
   logic [DEP_W-1:0] dep_cnt;
   logic             dep_run, depart;
   logic [GT_W-1:0]  gt;
   logic             gt_done;
   logic             err_now;

   // Detector conditioning: 2-flop synchroniser then a stable-run debouncer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= car_raw;
         sync2 <= sync1;
      end
   end

   assign deb_hit = (sync2 != deb_lvl) && (deb_cnt == DEB_W'(DEB_CYC - 1));
   assign arrival = deb_hit && sync2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_lvl <= 1'b0;
         deb_cnt <= '0;
      end else if (sync2 == deb_lvl || deb_hit) begin
         deb_cnt <= '0;
         if (deb_hit) deb_lvl <= sync2;
      end else begin
         deb_cnt <= deb_cnt + 1'b1;
      end
   end

   // One vehicle leaves per DEP_CYC cycles of farm-road green.
   assign dep_run = (cw == GRN) && (car_count != '0);
   assign depart  = dep_run && (dep_cnt == DEP_W'(DEP_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                dep_cnt <= '0;
      else if (!dep_run || depart) dep_cnt <= '0;
      else                       dep_cnt <= dep_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         car_count <= '0;
      end else if (arrival && !depart) begin
         if (car_count != CNT_MAX) car_count <= car_count + 1'b1;
      end else if (depart && !arrival) begin
         if (car_count != '0) car_count <= car_count - 1'b1;
      end
   end

   assign q_full = (car_count == CNT_MAX);

   // Green timer is held at zero outside SERVE, so it restarts on every entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              gt <= '0;
      else if (state != SERVE) gt <= '0;
      else                     gt <= gt + 1'b1;
   end

   assign gt_done = (gt == GT_W'(MAX_GREEN - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         x     <= 1'b0;
      end else begin
         state <= state_nxt;
         x     <= (state_nxt == REQUEST) || (state_nxt == SERVE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (car_count != '0) state_nxt = REQUEST;
         REQUEST: if (cw == GRN) state_nxt = SERVE;
         SERVE:   if (car_count == '0 || gt_done || cw != GRN) state_nxt = YIELD;
         YIELD:   if (hw == GRN) state_nxt = (car_count != '0) ? REQUEST : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign err_now = (hw != RED && cw != RED) || hw == BAD || cw == BAD ||
                    (cw == GRN && state == IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       light_err <= 1'b0;
      else if (err_now) light_err <= 1'b1;
   end

endmodule

// File: tb/tb_farm_road_sensor.sv
// Directed bench for farm_road_sensor: debounce, drain, max-green, collisions, safety.
module tb_farm_road_sensor;

   logic       clk = 1'b0;
   logic       reset;
   logic       car_raw;
   logic [1:0] hw, cw;
   logic       x;
   logic [3:0] car_count;
   logic       q_full;
   logic       light_err;

   int n_cmp = 0;
   int n_err = 0;

   farm_road_sensor #(.DEB_CYC(4), .DEP_CYC(8), .MAX_GREEN(32), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .car_raw(car_raw), .hw(hw), .cw(cw),
      .x(x), .car_count(car_count), .q_full(q_full), .light_err(light_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clean car: count bumps on the 6th edge after the raw rise.
   task automatic car();
      car_raw = 1'b1;
      step(6);
      car_raw = 1'b0;
      step(6);
   endtask

   initial begin
      reset = 1'b0; car_raw = 1'b0; hw = 2'b10; cw = 2'b00;
      #1;
      chk("rst_x", x, 0);
      chk("rst_cnt", car_count, 0);
      chk("rst_err", light_err, 0);
      step(2);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("idle_x", x, 0);
         chk("idle_cnt", car_count, 0);
         chk("idle_err", light_err, 0);
      end

      // Glitch shorter than the debounce window
      car_raw = 1'b1; step(2); car_raw = 1'b0; step(10);
      chk("glitch_cnt", car_count, 0);
      car_raw = 1'b1;
      step(5); chk("arr_pre_cnt", car_count, 0);
      step(1); chk("arr_cnt", car_count, 1); chk("arr_x_pre", x, 0);
      step(1); chk("arr_x", x, 1);
      step(3); car_raw = 1'b0; step(6);
      chk("arr_hold_cnt", car_count, 1);

      // Drain three cars
      car(); car();
      chk("drain_start", car_count, 3);
      hw = 2'b00; cw = 2'b10;
      step(7); chk("drain_c3", car_count, 3);
      step(1); chk("drain_c2", car_count, 2);
      step(8); chk("drain_c1", car_count, 1);
      step(8); chk("drain_c0", car_count, 0); chk("drain_x_hold", x, 1);
      step(1); chk("drain_x_drop", x, 0);
      cw = 2'b00; hw = 2'b10;
      step(1); chk("drain_idle_x", x, 0);
      step(2); chk("drain_idle_x2", x, 0); chk("drain_err", light_err, 0);

      // Max green with a saturated queue
      for (int i = 0; i < 15; i++) car();
      chk("full_cnt", car_count, 15);
      chk("full_q", q_full, 1);
      car();
      chk("sat_cnt", car_count, 15);
      hw = 2'b00; cw = 2'b10;
      step(32); chk("mg_x_hold", x, 1); chk("mg_cnt32", car_count, 11);
      step(1);  chk("mg_x_drop", x, 0); chk("mg_cnt33", car_count, 11);
      chk("mg_qfull", q_full, 0);
      cw = 2'b00; hw = 2'b10;
      step(1);  chk("mg_x_reassert", x, 1);

      // Arrival coinciding with a departure
      reset = 1'b0; #1; reset = 1'b1;
      car(); car();
      chk("sim_start", car_count, 2);
      hw = 2'b00; cw = 2'b10;
      step(2); car_raw = 1'b1;
      step(5); chk("sim_pre", car_count, 2);
      step(1); chk("sim_both", car_count, 2);
      car_raw = 1'b0;
      step(7); chk("sim_c2", car_count, 2);
      step(1); chk("sim_c1", car_count, 1);

      // Arrival while yielding
      cw = 2'b00;
      step(1); chk("yld_x", x, 0);
      car();
      chk("yld_cnt", car_count, 2);
      chk("yld_x_hold", x, 0);
      hw = 2'b10;
      step(1); chk("yld_x_back", x, 1);
      chk("yld_err", light_err, 0);

      // Conflicting greens, then reset mid-SERVE
      cw = 2'b10; step(1); cw = 2'b00;
      chk("conf_err", light_err, 1);
      step(3); chk("conf_sticky", light_err, 1);
      hw = 2'b00; cw = 2'b10;
      step(2); chk("serve_x", x, 1); chk("serve_cnt", car_count, 2);
      reset = 1'b0; #1;
      chk("mid_rst_x", x, 0);
      chk("mid_rst_cnt", car_count, 0);
      chk("mid_rst_err", light_err, 0);

      // Invalid encoding and farm green while idle
      hw = 2'b10; cw = 2'b00;
      step(1); reset = 1'b1;
      step(3); chk("post_rst_err", light_err, 0);
      hw = 2'b11; step(1); hw = 2'b10;
      chk("bad_enc_err", light_err, 1);
      reset = 1'b0; #1; reset = 1'b1;
      hw = 2'b00; cw = 2'b10;
      step(1); chk("idle_green_err", light_err, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/farm_road_sensor.md
Name: farm_road_sensor

Overview:
- Roadside end of the highway/farm-road signal interface: produces the `x` vehicle-request input consumed by the signal controller, and monitors the controller's `hw`/`cw` light outputs.
- Conditions a raw vehicle-detector loop: synchronise, debounce, count queued vehicles.
- Asserts `x` while farm-road traffic waits; drops `x` when the queue drains or a maximum farm green expires.
- Flags unsafe light combinations.

Parameters:
- DEB_CYC, 4: consecutive stable synchronised samples needed to accept a `car_raw` level change.
- DEP_CYC, 8: clk cycles of `cw`==green per departing vehicle.
- MAX_GREEN, 32: max clk cycles `x` is held during `cw`==green before yielding.
- CNT_W, 4: width of the vehicle queue counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- car_raw  input  1  raw detector loop, asynchronous to clk, may bounce.
- hw  input  2  highway light from controller (00 red, 01 yellow, 10 green; 11 invalid).
- cw  input  2  farm-road light from controller, same encoding.
- x  output  1  registered vehicle request to the signal controller.
- car_count  output  CNT_W  vehicles currently queued on the farm road.
- q_full  output  1  `car_count` == 2^CNT_W-1 (saturated).
- light_err  output  1  sticky safety error.

Behaviour:
- Reset (`reset`=0, async): state IDLE; `x`, `car_count`, `q_full`, `light_err`, sync flops and debounce counter all 0. Debounced level resets to 0.
- Synchroniser: 2-flop on `car_raw`.
- Debounce:
  - Counter increments while the synchronised level differs from the debounced level; clears to 0 when they match.
  - When it reaches DEB_CYC, debounced level toggles and counter clears.
  - A 0->1 toggle is one arrival pulse, generated in the cycle the level updates.
  - Latency: raw edge to arrival is 2 + DEB_CYC cycles. Glitches shorter than DEB_CYC synced cycles are ignored.
- Departure timer:
  - Runs only while `cw`==green (10) and `car_count`!=0.
  - Emits one departure pulse every DEP_CYC cycles.
  - Clears when `cw`!=green or `car_count`==0.
- Counter update per cycle:
  - Arrival only: +1, saturating at max; `q_full` asserted while at max.
  - Departure only: -1, never below 0.
  - Both in the same cycle: unchanged.
- Green timer:
  - Counts cycles in SERVE; clears on entering SERVE.
  - Reaching MAX_GREEN forces YIELD.
- FSM states IDLE, REQUEST, SERVE, YIELD. `x` is registered, =1 in REQUEST and SERVE, =0 in IDLE and YIELD.
  - IDLE -> REQUEST: `car_count`!=0 (including the cycle after an arrival increments the count).
  - REQUEST -> SERVE: `cw`==green.
  - SERVE -> YIELD: `car_count`==0, or green timer == MAX_GREEN.
  - SERVE -> YIELD also when `cw` leaves green unexpectedly.
  - YIELD -> REQUEST: `hw`==green and `car_count`!=0.
  - YIELD -> IDLE: `hw`==green and `car_count`==0.
  - Arrivals in YIELD are counted but do not re-assert `x` until `hw` returns to green. This guarantees the controller completes the S3->S4->S0 sequence.
- `light_err` is set and held until reset when any of these occur:
  - `hw` and `cw` are both non-red.
  - Either input is 11.
  - `cw`==green while the FSM is in IDLE.
- `light_err` does not alter FSM behaviour.
- Reset mid-operation: everything returns to its reset value immediately. The queue count is lost and `x` drops asynchronously.

Test Plan:
- Reset with `car_raw`=0, `hw`=10, `cw`=00; release reset; hold 20 cycles -> `x`=0, `car_count`=0, `light_err`=0 throughout.
- Glitch filter: `car_raw` high 2 cycles then low (DEB_CYC=4) -> `car_count` stays 0. Then high 10 cycles -> `car_count`=1 exactly 6 cycles after the raw edge, and `x`=1 the following cycle.
- Drain: 3 cars queued; controller drives `cw`=10, `hw`=00 -> `car_count` 3->2->1->0 at 8-cycle intervals; `x` falls the cycle after the count reaches 0. Then `hw`=10 -> state IDLE, `x`=0.
- Max green: 15 cars queued (`q_full`=1; a 16th arrival leaves `car_count`=15); `cw`=10 -> `x` drops after 32 cycles with `car_count`=11. When `hw` returns to 10, `x` re-asserts.
- Simultaneous events: arrival in the same cycle as a departure with `car_count`=2 -> `car_count` stays 2. Arrival during YIELD -> `car_count` increments, `x` stays 0 until `hw`=10.
- Safety: drive `hw`=10 and `cw`=10 for 1 cycle -> `light_err`=1 and sticky. Assert `reset`=0 mid-SERVE -> `x`, `car_count`, `light_err` all 0 immediately.
